fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_skid_buf.sv | 80 ++++++++
 rtl/fifo_stream_reader.sv | 126 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO-to-stream reader and its output buffer.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Words already committed to the output side: buffered plus the one still returning.
  function automatic logic [2:0] occupancy(input logic [1:0] buf_count, input logic inflight);
    return {1'b0, buf_count} + {2'b00, inflight};
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order output buffer: head feeds the stream, tail absorbs one extra word.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            count_q, count_d;

  // Next-state for entries and occupancy; a simultaneous push and pop keeps the count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push_i) begin
          head_d  = push_data_i;
          count_d = 2'd1;
        end else begin
          count_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_i && pop_i) begin
          head_d = push_data_i;
        end else if (push_i) begin
          tail_d  = push_data_i;
          count_d = 2'd2;
        end else if (pop_i) begin
          count_d = 2'd0;
        end else begin
          count_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_i) begin
          head_d = tail_q;
          if (push_i) begin
            tail_d = push_data_i;
          end else begin
            count_d = 2'd1;
          end
        end else begin
          count_d = 2'd2;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
  end

  // Entry and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a show-ahead-less FIFO (data one cycle after the strobe) and presents it as a valid/ready stream.
// Optional feature: define FIFO_STREAM_READER_CNT_EN to add the 16-bit xfer_cnt pop counter output.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_STREAM_READER_CNT_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);

  state_e      state_q, state_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  buf_count;
  logic [2:0]  occ;
  logic        pop;
  logic        room;
  logic        rd_en;

  assign m_valid = (buf_count != 2'd0);
  assign pop     = m_valid && m_ready;
  assign occ     = occupancy(buf_count, inflight_q);

  // A full pipeline may still issue when the head leaves this cycle, giving one word per cycle.
  always_comb begin
    room  = (occ <= 3'd1) || ((occ == 3'd2) && pop);
    rd_en = (state_q == ST_RUN) && en && !fifo_empty && room;
  end

  assign fifo_r_en  = rd_en;
  assign inflight_d = rd_en;

  // Run-control state machine: new reads only while running, drain finishes outstanding words.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (en) begin
          state_d = ST_RUN;
        end else if ((buf_count == 2'd0) && !inflight_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and in-flight read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_data),
    .pop_i       (pop),
    .head_o      (m_data),
    .count_o     (buf_count)
  );

`ifdef FIFO_STREAM_READER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    if (pop) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end else begin
      xfer_cnt_d = xfer_cnt_q;
    end
  end

  // Delivered-word counter, wraps modulo 2^16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_q <= 16'd0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: words written to a modelled FIFO must leave the stream in order, minus words lost at reset.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_r_en;
  logic [7:0] fifo_data = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       busy;
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  fifo_stream_reader #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    .xfer_cnt   (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int reads_total = 0;
  int pops_total = 0;
  int lost_total = 0;
  int ren_cnt = 0;
  logic [7:0] mq[$];     // contents of the upstream FIFO
  logic [7:0] exp_q[$];  // words expected on the stream, oldest first

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Upstream FIFO: an accepted read returns the head word one cycle later.
  always @(posedge clk) begin
    if (fifo_r_en && !fifo_empty && mq.size() > 0) begin
      fifo_data <= mq.pop_front();
      reads_total++;
    end
  end

  always @(posedge clk) begin
    #1;
    fifo_empty = (mq.size() == 0);
  end

  // Stream monitor and scoreboard.
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (fifo_r_en) ren_cnt++;
      if (fifo_empty) check("no_read_when_empty", {31'd0, fifo_r_en}, 32'd0);
      if (hold_v) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_data", {24'd0, m_data}, {24'd0, hold_d});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          check("stream_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
        pops_total++;
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mq.push_back(d);
    exp_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_delivered(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic apply_reset();
    int n;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_r_en", {31'd0, fifo_r_en}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    n = reads_total - lost_total - pops_total;
    for (int i = 0; i < n; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
    lost_total += n;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #700000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ren, first_val, last_val, nval, base;
    #1;
    check("init_r_en", {31'd0, fifo_r_en}, 32'd0);
    check("init_m_valid", {31'd0, m_valid}, 32'd0);
    check("init_m_data", {24'd0, m_data}, 32'd0);
    check("init_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Stream: three words back to back, two cycles after the first read strobe.
    push(8'h11); push(8'h22); push(8'h33);
    en = 1'b1; m_ready = 1'b1;
    first_ren = -1; first_val = -1; last_val = -1; nval = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_r_en && first_ren < 0) first_ren = i;
      if (m_valid) begin
        if (first_val < 0) first_val = i;
        last_val = i;
        nval++;
      end
    end
    check("stream_latency", first_val - first_ren, 32'd2);
    check("stream_nvalid", nval, 32'd3);
    check("stream_back_to_back", last_val - first_val, 32'd2);

    // Backpressure: at most two reads while stalled, head held.
    step();
    m_ready = 1'b0;
    base = ren_cnt;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (5) @(negedge clk);
    check("bp_reads_le2", {31'd0, (ren_cnt - base) <= 2}, 32'd1);
    check("bp_valid", {31'd0, m_valid}, 32'd1);
    check("bp_head", {24'd0, m_data}, 32'h11);
    step();
    m_ready = 1'b1;
    wait_delivered(40, "bp_delivered");

    // Empty: running with nothing to read.
    base = ren_cnt;
    repeat (10) @(negedge clk);
    check("empty_no_reads", ren_cnt - base, 32'd0);
    check("empty_m_valid", {31'd0, m_valid}, 32'd0);
    check("empty_busy", {31'd0, busy}, 32'd1);

    // Drain: stop while words are held and in flight.
    step();
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    repeat (3) step();
    en = 1'b0; m_ready = 1'b0;
    step();
    base = ren_cnt;
    repeat (4) @(negedge clk);
    check("drain_busy_held", {31'd0, busy}, 32'd1);
    check("drain_valid_held", {31'd0, m_valid}, 32'd1);
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 30 && busy; i++) @(negedge clk);
    check("drain_idle", {31'd0, busy}, 32'd0);
    check("drain_no_reads", ren_cnt - base, 32'd0);
    check("drain_all_delivered", reads_total - lost_total, pops_total);

    // Reset mid-operation, then continue with the next FIFO entry.
    step();
    m_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    repeat (6) step();
    check("rst_pre_valid", {31'd0, m_valid}, 32'd1);
    apply_reset();
    m_ready = 1'b1;
    wait_delivered(60, "rst_resume_delivered");

    // Randomized traffic with stalls and run/stop toggles.
    for (int c = 0; c < 400; c++) begin
      step();
      if ($urandom_range(0, 2) != 0 && mq.size() < 6) push(8'($urandom_range(0, 255)));
      m_ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 19) != 0);
    end
    step();
    en = 1'b1; m_ready = 1'b1;
    wait_delivered(100, "random_delivered");

`ifdef FIFO_STREAM_READER_CNT_EN
    // Counter wraps after 65536 pops.
    apply_reset();
    en = 1'b1; m_ready = 1'b1;
    base = 0;
    while (base < 65537) begin
      step();
      if (mq.size() < 4) begin
        push(8'(base));
        base++;
      end
    end
    wait_delivered(100, "cnt_delivered");
    check("xfer_cnt_wrap", {16'd0, xfer_cnt}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
